// File: rtl/tic_tac_toe_keypad.sv
// Keypad front end for tic_tac_toe: sync, debounce, one clean pulse per press.
// Optional TTT_KEYPAD_CELL_CODE_EN adds a registered 4-bit cell_code output.
module tic_tac_toe_keypad #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btn_raw,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       i,
  output logic       busy,
  output logic       multi_err
`ifdef TTT_KEYPAD_CELL_CODE_EN
  ,
  output logic [3:0] cell_code
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LOCKOUT
  } state_e;

  logic [SYNC_STAGES-1:0][8:0] sync_q;
  logic [8:0]    sync_w;
  logic [8:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [9];
  logic [CW-1:0] cnt_d [9];

  state_e     state_q, state_d;
  logic [8:0] pulse_q, pulse_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       one_hot;
  logic [3:0] code_w;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Counter only runs while sync disagrees; any agreement restarts it.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      deb_d[k] = deb_q[k];
      cnt_d[k] = '0;
      if (sync_w[k] != deb_q[k]) begin
        if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1))
          deb_d[k] = ~deb_q[k];
        else
          cnt_d[k] = cnt_q[k] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      deb_q  <= '0;
      for (int k = 0; k < 9; k++)
        cnt_q[k] <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      deb_q  <= deb_d;
      for (int k = 0; k < 9; k++)
        cnt_q[k] <= cnt_d[k];
    end
  end

  assign one_hot = (deb_q != '0) &&
                   ((deb_q & (deb_q - 9'd1)) == '0);

  always_comb begin
    code_w = '0;
    for (int k = 0; k < 9; k++)
      if (deb_q[k]) code_w = 4'(k + 1);
  end

  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (one_hot) begin
          pulse_d = deb_q;
          state_d = HELD;
        end else if (deb_q != '0) begin
          err_d   = 1'b1;
          state_d = LOCKOUT;
        end
      end
      HELD, LOCKOUT: begin
        if (deb_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pulse_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

`ifdef TTT_KEYPAD_CELL_CODE_EN
  logic [3:0] code_q, code_d;

  always_comb begin
    code_d = code_q;
    if (state_q == IDLE && one_hot) code_d = code_w;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) code_q <= '0;
    else        code_q <= code_d;
  end

  assign cell_code = code_q;
`else
  logic unused_code;
  assign unused_code = ^code_w;
`endif

  assign {i, h, g, f, e, d, c, b, a} = pulse_q;
  assign busy      = busy_q;
  assign multi_err = err_q;

endmodule

// File: tb/tb_tic_tac_toe_keypad.sv
// Directed bench for tic_tac_toe_keypad (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Table of hold/release records plus hand sequences for latency and reset.
module tb_tic_tac_toe_keypad;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] btn_raw;
  logic       a, b, c, d, e, f, g, h, i;
  logic       busy, multi_err;
`ifdef TTT_KEYPAD_CELL_CODE_EN
  logic [3:0] cell_code;
`endif
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;
  int excl   = 0;

  tic_tac_toe_keypad #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .f(f), .g(g), .h(h), .i(i),
    .busy(busy),
    .multi_err(multi_err)
`ifdef TTT_KEYPAD_CELL_CODE_EN
    ,
    .cell_code(cell_code)
`endif
  );

  always #5 clk = ~clk;

  assign outs = {i, h, g, f, e, d, c, b, a};

  always @(negedge clk)
    if (($countones(outs) + int'(multi_err)) > 1) excl++;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [8:0] btn;
    int         cyc;
    logic [8:0] exp_cells;
    int         exp_err;
    logic       exp_busy;
  } vec_t;

  vec_t tv [12];

  task automatic run_vec(input int n, input vec_t v);
    int pc [9];
    int ec;
    int total;
    logic [8:0] mask;
    ec = 0;
    for (int k = 0; k < 9; k++) pc[k] = 0;
    btn_raw = v.btn;
    repeat (v.cyc) begin
      @(negedge clk);
      for (int k = 0; k < 9; k++) if (outs[k]) pc[k]++;
      if (multi_err) ec++;
    end
    total = 0;
    mask  = '0;
    for (int k = 0; k < 9; k++) begin
      total += pc[k];
      if (pc[k] != 0) mask[k] = 1'b1;
    end
    chk($sformatf("vec%0d_cells", n), int'(mask), int'(v.exp_cells));
    chk($sformatf("vec%0d_npulse", n), total, $countones(v.exp_cells));
    chk($sformatf("vec%0d_err", n), ec, v.exp_err);
    chk($sformatf("vec%0d_busy", n), int'(busy), int'(v.exp_busy));
  endtask

  initial begin
    tv[0]  = '{9'h000, 50, 9'h000, 0, 1'b0};
    tv[1]  = '{9'h080, 40, 9'h080, 0, 1'b1};
    tv[2]  = '{9'h000, 20, 9'h000, 0, 1'b0};
    tv[3]  = '{9'h011, 20, 9'h000, 1, 1'b1};
    tv[4]  = '{9'h000, 20, 9'h000, 0, 1'b0};
    tv[5]  = '{9'h010, 20, 9'h010, 0, 1'b1};
    tv[6]  = '{9'h000, 20, 9'h000, 0, 1'b0};
    tv[7]  = '{9'h004, 20, 9'h004, 0, 1'b1};
    tv[8]  = '{9'h044, 20, 9'h000, 0, 1'b1};
    tv[9]  = '{9'h000, 20, 9'h000, 0, 1'b0};
    tv[10] = '{9'h040, 20, 9'h040, 0, 1'b1};
    tv[11] = '{9'h000, 20, 9'h000, 0, 1'b0};

    reset   = 1'b0;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'(outs), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(multi_err), 0);
    reset = 1'b1;

    for (int n = 0; n < 12; n++) run_vec(n, tv[n]);

    // Press latency on h: first sampling edge is j=1, pulse during j=7.
    btn_raw = 9'h080;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 6) chk("h_pre", int'(h), 0);
      if (j == 6) chk("h_busy_pre", int'(busy), 0);
      if (j == 7) chk("h_pulse", int'(h), 1);
      if (j == 7) chk("h_busy_rise", int'(busy), 1);
      if (j == 8) chk("h_post", int'(h), 0);
    end
    btn_raw = '0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 6) chk("h_busy_hold", int'(busy), 1);
      if (j == 7) chk("h_busy_fall", int'(busy), 0);
    end

    // Bounce on a: 2-cycle runs never reach 4, then a clean hold.
    begin
      int bp;
      bp = 0;
      for (int j = 0; j < 20; j++) begin
        btn_raw = ((j / 2) % 2 == 0) ? 9'h001 : 9'h000;
        @(negedge clk);
        bp += $countones(outs);
      end
      chk("bounce_nopulse", bp, 0);
      chk("bounce_busy", int'(busy), 0);
    end
    btn_raw = 9'h001;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 6) chk("a_pre", int'(a), 0);
      if (j == 7) chk("a_pulse", int'(a), 1);
      if (j == 8) chk("a_post", int'(a), 0);
    end
    btn_raw = '0;
    repeat (20) @(negedge clk);

    // Reset while i is held: state clears, then a fresh debounce.
    btn_raw = 9'h100;
    begin
      int ip;
      ip = 0;
      repeat (20) begin
        @(negedge clk);
        ip += int'(i);
      end
      chk("i_first_pulse", ip, 1);
      chk("i_busy_held", int'(busy), 1);
`ifdef TTT_KEYPAD_CELL_CODE_EN
      chk("i_code", int'(cell_code), 9);
`endif
    end
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
`ifdef TTT_KEYPAD_CELL_CODE_EN
    chk("midrst_code", int'(cell_code), 0);
`endif
    repeat (2) @(negedge clk);
    chk("midrst_outs", int'(outs), 0);
    reset = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) chk("rel_busy", int'(busy), 0);
      if (j == 6) chk("i_re_pre", int'(i), 0);
      if (j == 7) chk("i_re_pulse", int'(i), 1);
      if (j == 8) chk("i_re_post", int'(i), 0);
`ifdef TTT_KEYPAD_CELL_CODE_EN
      if (j == 7) chk("i_re_code", int'(cell_code), 9);
`endif
    end
    btn_raw = '0;
    repeat (15) @(negedge clk);
    chk("final_busy", int'(busy), 0);
    chk("exclusive", excl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tic_tac_toe_keypad.md
Name: tic_tac_toe_keypad

Overview:
Input conditioner that sits directly upstream of tic_tac_toe. It takes the nine raw, bouncing grid push-buttons, synchronises and debounces each one, and accepts one cell per press. For each accepted press it drives exactly one of the a..i cell inputs of tic_tac_toe as a clean single-cycle pulse. Multi-button presses are rejected, and nothing is re-issued until every button has been released.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must disagree with its debounced state before that state flips; legal range 1..65535.
SYNC_STAGES, 2, synchroniser flops per button; legal range 2..3.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
btn_raw  input  9  raw buttons; bit0=a ... bit8=i; active-high, asynchronous, bouncing
a, b, c, d, e, f, g, h, i  output  1 each  cell-select pulses to tic_tac_toe; at most one high in any cycle
busy  output  1  high while a press is held or the keypad is locked out
multi_err  output  1  one-cycle pulse when a multi-button press is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchroniser flops, debounced states and debounce counters clear to 0.
  - FSM goes to IDLE.
  - a..i, busy and multi_err are 0 while reset is low and in the first cycle after release.
- Synchroniser: SYNC_STAGES flops per bit; its output is sync[8:0].
- Debounce, per bit:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
  - If sync != deb, the counter increments. When the count reaches DEBOUNCE_CYCLES, deb toggles and the counter clears, in the same edge.
  - If sync == deb, the counter clears. Any bounce therefore restarts the count.
  - The counter never wraps.
- Latency: a raw level held stable from clock edge N reaches deb at edge N+SYNC_STAGES+DEBOUNCE_CYCLES-1. The output pulse is registered, so it is high during the cycle after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
- FSM, three states, evaluated on deb[8:0]:
  - IDLE, deb == 0: stay in IDLE.
  - IDLE, exactly one bit set: assert the matching output for one cycle and go to HELD.
  - IDLE, two or more bits set in the same cycle: pulse multi_err for one cycle, no cell pulse, go to LOCKOUT.
  - HELD: no pulses. Extra buttons pressed while held are ignored and produce no multi_err. Return to IDLE when deb == 0.
  - LOCKOUT: no pulses. Return to IDLE when deb == 0.
- busy = (state != IDLE), registered with the state.
- A button held continuously yields exactly one pulse, whatever the hold time.
- Re-press: a new pulse requires a full return to IDLE, meaning all nine bits debounced low.
- Outputs a..i and multi_err are mutually exclusive in every cycle.
- Reset asserted mid-press: all state clears. A button still held through reset release must debounce again from 0 and then produces one pulse.

Optional Feature:
Macro: TTT_KEYPAD_CELL_CODE_EN
- Defined: adds output cell_code, 4 bits.
  - Registered in the same cycle as the cell pulse: 1..9 for a..i.
  - Holds its value until the next accepted press.
  - Cleared to 0 by reset; never updated by rejected presses.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
1. Reset and settle: reset low 3 cycles, then high, btn_raw=0 for 50 cycles -> a..i, busy and multi_err all stay 0.
2. Clean press on h: DEBOUNCE_CYCLES=4, btn_raw=9'h080 held 40 cycles, then 0.
   - h pulses high for exactly 1 cycle, SYNC_STAGES+DEBOUNCE_CYCLES+1 = 7 cycles after the first sampling edge.
   - busy rises with the pulse and falls DEBOUNCE_CYCLES+SYNC_STAGES cycles after the release.
   - No second pulse.
3. Bounce on a: DEBOUNCE_CYCLES=4, toggle bit0 every 2 cycles for 20 cycles, then hold high -> no pulse during the bouncing; one pulse on a exactly 7 cycles after the final stable edge.
4. Simultaneous press: btn_raw=9'h011 (a and e) applied in the same cycle -> multi_err pulses once, no cell pulse, busy=1. After release and debounce, busy=0. A following clean press on e yields one e pulse.
5. Held then extra: hold c until its pulse, then add g while c is still held, release both, then press g -> no pulse and no multi_err on the first g; exactly one g pulse on the second press.
6. Reset mid-hold, with TTT_KEYPAD_CELL_CODE_EN defined: press i (cell_code=9), assert reset for 2 cycles while i is still held -> cell_code=0 and busy=0. After reset release, i pulses again after a full debounce and cell_code=9.
